// File: rtl/instruction_fetch.sv
// Fetch stage: requests the byte at pc, holds it for decode and pulses
// pc_inc once per fetched instruction. Supports flush and HALT.
module instruction_fetch #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_inc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              flush,
   output logic              halted,
   output logic [7:0]        fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_HALT
   } state_t;

   state_t            state_q;
   logic              pc_inc_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic              valid_q;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] instr_pc_q;
   logic              halted_q;
   logic [7:0]        cnt_q;

   logic              hs;
   logic [ADDR_W-1:0] next_pc;

   assign hs = valid_q & instr_ready;

   // pc has not yet advanced if decode accepts during the pc_inc cycle
   assign next_pc = pc + {{(ADDR_W-1){1'b0}}, pc_inc_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_inc_q   <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         halted_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (hs) begin
            cnt_q <= cnt_q + 8'd1;
         end
         pc_inc_q <= 1'b0;
         if (flush) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
                  addr_q  <= pc;
               end
               S_REQ: begin
                  if (mem_ready) begin
                     state_q    <= S_HOLD;
                     req_q      <= 1'b0;
                     instr_q    <= mem_rdata;
                     instr_pc_q <= addr_q;
                     valid_q    <= 1'b1;
                     pc_inc_q   <= 1'b1;
                  end
               end
               S_HOLD: begin
                  if (instr_ready) begin
                     valid_q <= 1'b0;
                     if (instr_q == HALT_OPCODE) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                     end else begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= next_pc;
                     end
                  end
               end
               S_HALT: begin
                  state_q <= S_HALT;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign pc_inc      = pc_inc_q & ~flush;
   assign mem_req     = req_q;
   assign mem_addr    = addr_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign halted      = halted_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: models the PC and memory, scoreboards every
// accepted instruction against program order, plus directed corner cases.
module tb_instruction_fetch;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pc;
   logic       pc_inc;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ready;
   logic [7:0] mem_rdata;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       flush;
   logic       halted;
   logic [7:0] fetch_count;

   always #5 clk = ~clk;

   instruction_fetch dut (
      .clk(clk),
      .reset(reset),
      .pc(pc),
      .pc_inc(pc_inc),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr(instr),
      .instr_pc(instr_pc),
      .flush(flush),
      .halted(halted),
      .fetch_count(fetch_count)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];

   // environment knobs
   bit         rnd_mode = 0;
   int         mem_lat = 0;
   int         dec_lat = 0;
   bit         rst_now = 0;
   bit         flush_now = 0;
   bit         force_ready = 0;
   logic [7:0] flush_tgt = 8'h00;
   logic [7:0] pc_nxt = 8'h00;
   int         req_age = 0;
   int         val_age = 0;

   // reference model
   bit         in_reset = 0;
   bit         chk_zero = 0;
   logic [7:0] exp_addr;
   int         exp_cnt;
   bit         exp_halt;
   bit         cap_prev, req_prev, rdy_prev, flush_prev;
   logic [7:0] addr_prev;
   bit         hs_seen;
   logic [7:0] hs_pc, hs_instr;
   int         nhs;
   int         pinc_cnt;

   typedef struct {
      int         mem_lat;
      int         dec_lat;
      logic [7:0] data;
      logic [7:0] addr;
      int         cnt_before;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_init();
      exp_addr   = pc;
      exp_cnt    = 0;
      exp_halt   = 0;
      cap_prev   = 0;
      req_prev   = 0;
      rdy_prev   = 0;
      flush_prev = 0;
      addr_prev  = 8'h00;
   endtask

   task automatic monitor();
      bit hs;
      chk("pc_inc", pc_inc, cap_prev && !flush);
      chk("fetch_count", fetch_count, exp_cnt & 255);
      chk("halted", halted, exp_halt);
      if (exp_halt)
         chk("halt_quiet", mem_req | instr_valid | pc_inc, 0);
      if (req_prev && !rdy_prev && !flush_prev) begin
         chk("req_hold", mem_req, 1);
         chk("addr_hold", mem_addr, addr_prev);
      end
      if (mem_req && !req_prev)
         chk("req_addr", mem_addr, exp_addr);
      pinc_cnt += int'(pc_inc);
      hs = instr_valid && instr_ready;
      if (hs) begin
         chk("instr_pc", instr_pc, exp_addr);
         chk("instr", instr, mem[exp_addr]);
         hs_seen  = 1;
         hs_pc    = instr_pc;
         hs_instr = instr;
         nhs++;
         exp_cnt++;
         if (instr == 8'hFF && !flush) exp_halt = 1;
         exp_addr = exp_addr + 8'd1;
      end
      if (flush) begin
         exp_addr = flush_tgt;
         exp_halt = 0;
      end
      cap_prev   = mem_req && mem_ready && !flush;
      req_prev   = mem_req;
      rdy_prev   = mem_ready;
      flush_prev = flush;
      addr_prev  = mem_addr;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      pc    = pc_nxt;
      reset = rst_now;
      if (chk_zero) begin
         chk("rst_pc_inc", pc_inc, 0);
         chk("rst_mem_req", mem_req, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_valid", instr_valid, 0);
         chk("rst_instr", instr, 0);
         chk("rst_instr_pc", instr_pc, 0);
         chk("rst_halted", halted, 0);
         chk("rst_count", fetch_count, 0);
         model_init();
         chk_zero = 0;
         in_reset = 0;
      end
      if (rnd_mode) begin
         mem_ready   = ($urandom % 3) == 0;
         instr_ready = ($urandom % 2) == 0;
         flush_now   = ($urandom % 40) == 0;
         flush_tgt   = 8'($urandom);
      end else begin
         mem_ready   = force_ready || (mem_req && req_age >= mem_lat);
         instr_ready = instr_valid && val_age >= dec_lat;
      end
      mem_rdata = (mem_ready && mem_req) ? mem[mem_addr] : 8'($urandom);
      flush     = flush_now;
      @(negedge clk);
      if (!in_reset) monitor();
      pc_nxt  = flush ? flush_tgt : (pc_inc ? pc + 8'd1 : pc);
      req_age = (mem_req && !mem_ready) ? req_age + 1 : 0;
      val_age = (instr_valid && !instr_ready) ? val_age + 1 : 0;
   endtask

   task automatic do_reset();
      rst_now  = 1;
      in_reset = 1;
      cyc();
      rst_now  = 0;
      chk_zero = 1;
      cyc();
   endtask

   task automatic wait_hs(input string name);
      int n;
      n = 0;
      hs_seen = 0;
      while (!hs_seen && n < 60) begin
         cyc();
         n++;
      end
      if (!hs_seen) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      int n;
      int q;
      reset = 1'b1; pc = 8'h00; mem_ready = 0; mem_rdata = 0;
      instr_ready = 0; flush = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'((i * 7 + 3) & 8'h7F);

      tbl[0] = '{1, 0, 8'h3A, 8'h00, 0};
      tbl[1] = '{0, 0, 8'h11, 8'h01, 1};
      tbl[2] = '{0, 3, 8'h12, 8'h02, 2};
      tbl[3] = '{4, 0, 8'h44, 8'h03, 3};
      tbl[4] = '{2, 1, 8'h55, 8'h04, 4};
      tbl[5] = '{4, 2, 8'h66, 8'h05, 5};
      tbl[6] = '{0, 0, 8'h77, 8'h06, 6};
      for (int i = 0; i < 7; i++) mem[tbl[i].addr] = tbl[i].data;
      mem[8'h07] = 8'h99;
      mem[8'h20] = 8'hFF;

      pc_nxt = 8'h00;
      do_reset();

      for (int i = 0; i < 7; i++) begin
         mem_lat  = tbl[i].mem_lat;
         dec_lat  = tbl[i].dec_lat;
         pinc_cnt = 0;
         wait_hs("vec");
         chk("vec_pc", hs_pc, tbl[i].addr);
         chk("vec_instr", hs_instr, tbl[i].data);
         chk("vec_cnt_before", fetch_count, tbl[i].cnt_before);
         chk("vec_pinc", pinc_cnt, 1);
      end

      // flush in REQ at 07 with mem_ready in the same cycle
      mem_lat = 0; dec_lat = 0;
      force_ready = 1; flush_now = 1; flush_tgt = 8'h10;
      cyc();
      chk("fl_req", mem_req, 1);
      chk("fl_addr", mem_addr, 8'h07);
      force_ready = 0; flush_now = 0;
      cyc();
      chk("fl_idle_req", mem_req, 0);
      chk("fl_idle_valid", instr_valid, 0);
      chk("fl_idle_pinc", pc_inc, 0);
      chk("fl_instr_kept", instr, 8'h77);
      cyc();
      chk("fl_new_req", mem_req, 1);
      chk("fl_new_addr", mem_addr, 8'h10);

      // HALT at 20, then resume at 30
      flush_now = 1; flush_tgt = 8'h20;
      cyc();
      flush_now = 0;
      n = 0;
      while (!halted && n < 30) begin cyc(); n++; end
      chk("halt_set", halted, 1);
      q = 0;
      for (int i = 0; i < 20; i++) begin cyc(); q += int'(mem_req); end
      chk("halt_no_req", q, 0);
      flush_now = 1; flush_tgt = 8'h30;
      cyc();
      flush_now = 0;
      cyc();
      chk("resume_halted", halted, 0);
      cyc();
      chk("resume_req", mem_req, 1);
      chk("resume_addr", mem_addr, 8'h30);

      // fetch_count wrap after 256 accepted
      mem[8'h20] = 8'h00;
      mem_lat = 0; dec_lat = 0;
      do_reset();
      nhs = 0; n = 0;
      while (nhs < 256 && n < 1000) begin cyc(); n++; end
      chk("wrap_hs", nhs, 256);
      cyc();
      chk("wrap_count", fetch_count, 0);

      // reset in the middle of HOLD
      dec_lat = 5; n = 0;
      while (!instr_valid && n < 20) begin cyc(); n++; end
      chk("midhold_valid", instr_valid, 1);
      do_reset();

      // randomized traffic against the model
      for (int i = 0; i < 256; i++)
         mem[i] = (($urandom % 12) == 0) ? 8'hFF : 8'($urandom % 255);
      pc_nxt = 8'($urandom);
      rnd_mode = 1;
      do_reset();
      for (int i = 0; i < 3000; i++) cyc();
      rnd_mode = 0; flush_now = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly downstream of the 8-bit program counter. Consumes the current pc and requests the instruction byte from instruction memory through a req/ready handshake. Latches the byte into an instruction register and presents it to decode through a valid/ready handshake. Pulses pc_inc so the PC advances exactly once per fetched instruction; supports flush on branch/jump and a HALT opcode.

Parameters:
ADDR_W, 8, width of pc and memory address
DATA_W, 8, width of instruction byte
HALT_OPCODE, 8'hFF, instruction value that stops fetching after it is handed off

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
pc  input  ADDR_W  current program counter value
pc_inc  output  1  one-cycle pulse; PC increments on the following edge
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  read address, stable while mem_req=1
mem_ready  input  1  memory has mem_rdata valid this cycle
mem_rdata  input  DATA_W  instruction byte from memory
instr_valid  output  1  instr/instr_pc valid for decode
instr_ready  input  1  decode accepts instr this cycle
instr  output  DATA_W  instruction register
instr_pc  output  ADDR_W  address the instruction came from
flush  input  1  branch/jump taken; PC being loaded; discard in-flight fetch
halted  output  1  fetch stopped on HALT_OPCODE
fetch_count  output  8  count of instructions accepted by decode, wraps 255->0

Behaviour:
- Reset (synchronous, wins over everything): state=IDLE; pc_inc, mem_req, instr_valid, halted = 0; mem_addr, instr, instr_pc, fetch_count = 0.
- States: IDLE, REQ, HOLD, HALT.
- IDLE: all handshakes low; next cycle -> REQ, capturing pc into mem_addr on that edge.
- REQ: mem_req=1, mem_addr held. Cycle where mem_req=1 and mem_ready=1: on that edge, instr<=mem_rdata, instr_pc<=mem_addr, instr_valid<=1, mem_req<=0, state->HOLD. pc_inc=1 for exactly the first HOLD cycle (registered), so the PC updates at the end of that cycle.
- Memory latency is unbounded; mem_req/mem_addr stay constant until mem_ready.
- HOLD: instr_valid=1, instr/instr_pc stable until instr_valid & instr_ready. On handshake: fetch_count += 1 (mod 256); instr_valid<=0; if instr==HALT_OPCODE -> HALT, else -> REQ with mem_addr<=pc (the already-incremented value).
- Earliest back-to-back throughput: with mem_ready and instr_ready tied high, one instruction every 2 cycles (REQ, HOLD).
- HALT: halted=1, no mem_req, no pc_inc. Exits only via reset or flush.
- Flush (priority below reset, above all else): next state IDLE; instr_valid<=0, mem_req<=0, halted<=0; pc_inc forced 0 in the flush cycle and the following cycle. A mem_ready in the flush cycle is ignored and its data discarded. If flush coincides with instr_valid & instr_ready, the handshake still counts (fetch_count increments); the HALT transition is overridden by IDLE. IDLE gives the PC one cycle to take its loaded address before REQ resamples pc.
- pc_inc never asserts twice for one instruction; never asserts in IDLE, REQ or HALT.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset then pc=8'h00, memory returns 8'h3A at addr 00 with ready one cycle after req, instr_ready=1 -> mem_addr=00, instr=3A, instr_pc=00, single pc_inc pulse, fetch_count=1, next request at addr 01.
- Memory ready delayed 4 cycles -> mem_req and mem_addr=05 held stable all 4 cycles; no pc_inc until the data is captured.
- Decode backpressure: instr_ready=0 for 3 cycles in HOLD -> instr=8'h12 and instr_valid held; no new mem_req; one pc_inc only; fetch_count increments once on release.
- Flush during REQ with mem_ready=1 in the same cycle at addr 07, PC loaded to 8'h10 -> data discarded, no pc_inc, one IDLE cycle, next mem_addr=10.
- Memory returns 8'hFF at addr 20, accepted -> halted=1, mem_req stays 0 for 20 cycles; a later flush with pc=8'h30 -> halted=0, fetch resumes at 30.
- 256 accepted instructions from reset -> fetch_count wraps to 0; reset asserted mid-HOLD -> all outputs 0 on the next edge.
